seq_detector: RTL and testbench

SEQ_DETECTOR -- requirements
Module: seq_detector

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/sat_counter.sv | 34 +++
 rtl/seq_detector.sv | 75 +++++++
 tb/tb_seq_detector.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial 1101 pattern detector.
// Provides the Moore state encoding, the pattern and the default counter width.
package seq_det_pkg;

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S11   = 3'd2,
        S110  = 3'd3,
        S1101 = 3'd4
    } state_e;

    localparam int unsigned PatternLen  = 4;
    localparam logic [3:0]  PATTERN     = 4'b1101;
    localparam int unsigned CntWDefault = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             INC,
    output logic [WIDTH-1:0] COUNT
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (CLR) begin
            count_d = '0;
        end else if (INC && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT = count_q;

endmodule

// File: rtl/seq_detector.sv
// Overlapping Moore detector for serial pattern 1101 with a one-cycle DETECT
// pulse and a saturating match counter.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W       = CntWDefault,
    parameter int unsigned PATTERN_LEN = PatternLen
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             BIT_VALID,
    input  logic             BIT_IN,
    input  logic             CLR_CNT,
    output logic             DETECT,
    output logic [CNT_W-1:0] MATCH_CNT,
    output logic [2:0]       STATE
);

    localparam logic [PATTERN_LEN-1:0] Pat = PATTERN;

    state_e state_q, state_d;
    logic   detect_q;
    logic   enter_match;

    // Each partial-match state advances only when the next expected pattern bit arrives.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S0: begin
                if (BIT_VALID) state_d = (BIT_IN == Pat[3]) ? S1 : S0;
            end
            S1: begin
                if (BIT_VALID) state_d = (BIT_IN == Pat[2]) ? S11 : S0;
            end
            S11: begin
                if (BIT_VALID) state_d = (BIT_IN == Pat[1]) ? S110 : S11;
            end
            S110: begin
                if (BIT_VALID) state_d = (BIT_IN == Pat[0]) ? S1101 : S0;
            end
            S1101: begin
                // Trailing "1" of a match is the first "1" of the next one.
                if (BIT_VALID) state_d = BIT_IN ? S11 : S0;
            end
            default: state_d = S0;
        endcase
    end

    // Holding S1101 with no new bit must not re-fire DETECT.
    assign enter_match = (state_d == S1101) && (state_q != S1101);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S0;
            detect_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            detect_q <= enter_match;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_match_cnt (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (CLR_CNT),
        .INC  (enter_match),
        .COUNT(MATCH_CNT)
    );

    assign DETECT = detect_q;
    assign STATE  = state_q;

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: directed scenarios plus random bit streams
// compared cycle by cycle against a bit-history reference model.
module tb_seq_detector;

    localparam int CW     = 8;
    localparam int CntMax = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST, BIT_VALID, BIT_IN, CLR_CNT;
    logic          DETECT;
    logic [CW-1:0] MATCH_CNT;
    logic [2:0]    STATE;

    int         n_tests  = 0;
    int         n_fail   = 0;
    int         det_seen = 0;
    logic [3:0] m_hist;
    int         m_cnt;
    bit         m_det;

    seq_detector #(
        .CNT_W(CW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BIT_VALID(BIT_VALID),
        .BIT_IN   (BIT_IN),
        .CLR_CNT  (CLR_CNT),
        .DETECT   (DETECT),
        .MATCH_CNT(MATCH_CNT),
        .STATE    (STATE)
    );

    always #5 CLK = ~CLK;

    // Longest suffix of the consumed bits that is a prefix of 1101.
    function automatic int exp_state(input logic [3:0] h);
        if (h == 4'b1101) return 4;
        if (h[2:0] == 3'b110) return 3;
        if (h[1:0] == 2'b11) return 2;
        if (h[0]) return 1;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit rst, input bit v, input bit b, input bit clr);
        RST       = rst;
        BIT_VALID = v;
        BIT_IN    = b;
        CLR_CNT   = clr;
        @(posedge CLK);
        if (rst) begin
            m_hist = 4'b0000;
            m_cnt  = 0;
            m_det  = 1'b0;
        end else begin
            if (v) m_hist = {m_hist[2:0], b};
            m_det = v && (m_hist == 4'b1101);
            if (clr) m_cnt = 0;
            else if (m_det && m_cnt < CntMax) m_cnt++;
        end
        #1;
        if (DETECT === 1'b1) det_seen++;
        check("detect", DETECT, m_det);
        check("match_cnt", MATCH_CNT, m_cnt);
        check("state", STATE, exp_state(m_hist));
    endtask

    task automatic send(input logic [15:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            tick(1'b0, 1'b1, bits[i], 1'b0);
            for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 1'($urandom), 1'b0);
        end
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        det_seen = 0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("reset_state", STATE, 0);
        check("reset_cnt", MATCH_CNT, 0);
        check("reset_detect", DETECT, 0);

        // Back-to-back overlapping stream 1101101
        send(16'b1101101, 7, 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("overlap_cnt", MATCH_CNT, 2);
        check("overlap_pulses", det_seen, 2);

        // Same stream with three idle cycles between bits
        do_reset();
        send(16'b1101101, 7, 3);
        check("gapped_cnt", MATCH_CNT, 2);
        check("gapped_pulses", det_seen, 2);

        // No match in 11110000
        do_reset();
        send(16'b11110000, 8, 0);
        check("nomatch_cnt", MATCH_CNT, 0);
        check("nomatch_pulses", det_seen, 0);
        check("nomatch_state", STATE, 0);

        // 300 non-overlapping patterns saturate the counter
        do_reset();
        for (int p = 0; p < 300; p++) send(16'b1101, 4, 0);
        check("sat_cnt", MATCH_CNT, CntMax);
        check("sat_pulses", det_seen, 300);

        // Clear on the edge completing a match, with count at 5
        do_reset();
        for (int p = 0; p < 5; p++) send(16'b1101, 4, 0);
        check("pre_clr_cnt", MATCH_CNT, 5);
        send(16'b110, 3, 0);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        check("clr_win_cnt", MATCH_CNT, 0);
        check("clr_win_detect", DETECT, 1);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        check("clr_win_pulse_end", DETECT, 0);

        // Reset discards a partial match
        do_reset();
        send(16'b110, 3, 0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        check("rst_partial_state", STATE, 1);
        check("rst_partial_detect", DETECT, 0);
        check("rst_partial_cnt", MATCH_CNT, 0);

        // Random traffic with occasional clear and reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom % 300) == 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
                 ($urandom % 60) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
